// File: rtl/frv_serial_shift_pkg.sv
// rtl/frv_serial_shift_pkg.sv - shared encodings and constants for the serial shift stage
package frv_serial_shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int FAST_STEP = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/frv_serial_shift_step.sv
// rtl/frv_serial_shift_step.sv - combinational shift of the accumulator by a small step amount
module frv_serial_shift_step
    import frv_serial_shift_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [2:0]      amt_i,
    output logic [XLEN-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        case (op_i)
            OP_SLL:  acc_o = acc_i << amt_i;
            OP_SRL:  acc_o = acc_i >> amt_i;
            OP_SRA:  acc_o = $unsigned($signed(acc_i) >>> amt_i);
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/frv_serial_shift_stage.sv
// rtl/frv_serial_shift_stage.sv - multi-cycle serial shifter on the valid/busy handshake; FRV_SERIAL_SHIFT_FAST_EN enables 4-bit steps
module frv_serial_shift_stage
    import frv_serial_shift_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SLEN  = $clog2(XLEN),
    parameter int RDLEN = 5
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             s_valid,
    output logic             s_busy,
    input  logic [1:0]       s_op,
    input  logic [XLEN-1:0]  s_rs1,
    input  logic [SLEN-1:0]  s_shamt,
    input  logic [RDLEN-1:0] s_rd,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_busy,
    output logic [XLEN-1:0]  m_result,
    output logic [RDLEN-1:0] m_rd
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [SLEN-1:0]  cnt_q, cnt_d;
    logic [RDLEN-1:0] rd_q, rd_d;

    logic [2:0]       step_amt;
    logic [XLEN-1:0]  step_out;
    logic             accept;

    assign s_busy   = (state_q == SHIFT) || ((state_q == DONE) && m_busy);
    assign m_valid  = (state_q == DONE);
    assign m_result = acc_q;
    assign m_rd     = rd_q;
    assign accept   = s_valid && !s_busy && !flush;

`ifdef FRV_SERIAL_SHIFT_FAST_EN
    assign step_amt = (cnt_q >= SLEN'(FAST_STEP)) ? 3'(FAST_STEP) : 3'd1;
`else
    assign step_amt = 3'd1;
`endif

    frv_serial_shift_step #(
        .XLEN (XLEN)
    ) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .amt_i (step_amt),
        .acc_o (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;

        case (state_q)
            SHIFT: begin
                acc_d = step_out;
                cnt_d = cnt_q - SLEN'(step_amt);
                if (cnt_q == SLEN'(step_amt)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!m_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // A new op may land in the same cycle the previous result leaves.
        if (accept) begin
            op_d    = s_op;
            acc_d   = s_rs1;
            cnt_d   = s_shamt;
            rd_d    = s_rd;
            state_d = ((s_shamt == '0) || (s_op == OP_RSV)) ? DONE : SHIFT;
        end

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            acc_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_frv_serial_shift_stage.sv
// tb/tb_frv_serial_shift_stage.sv - self-checking bench with a transaction-level shifter model
module tb_frv_serial_shift_stage;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        s_valid;
    logic        s_busy;
    logic [1:0]  s_op;
    logic [31:0] s_rs1;
    logic [4:0]  s_shamt;
    logic [4:0]  s_rd;
    logic        flush;
    logic        m_valid;
    logic        m_busy;
    logic [31:0] m_result;
    logic [4:0]  m_rd;

    int total = 0;
    int bad   = 0;

    // Model: one pending operation, the cycle its result appears, and its value.
    logic        mdl_has = 1'b0;
    longint      mdl_ready = 0;
    longint      cyc = 0;
    logic [31:0] mdl_res = '0;
    logic [4:0]  mdl_rd = '0;

    always #5 g_clk = ~g_clk;

    frv_serial_shift_stage dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .s_valid  (s_valid),
        .s_busy   (s_busy),
        .s_op     (s_op),
        .s_rs1    (s_rs1),
        .s_shamt  (s_shamt),
        .s_rd     (s_rd),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_busy   (m_busy),
        .m_result (m_result),
        .m_rd     (m_rd)
    );

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] v, input int n);
        logic signed [31:0] sv;
        sv = v;
        case (op)
            2'b00:   return v << n;
            2'b01:   return v >> n;
            2'b10:   return sv >>> n;
            default: return v;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input int n);
        if (op == 2'b11 || n == 0) return 0;
`ifdef FRV_SERIAL_SHIFT_FAST_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] rs1,
                         input logic [4:0] sh, input logic [4:0] rd,
                         input logic fl, input logic mb, input logic rn);
        logic exp_mv, exp_sb;
        @(negedge g_clk);
        s_valid = v; s_op = op; s_rs1 = rs1; s_shamt = sh; s_rd = rd;
        flush = fl; m_busy = mb; g_resetn = rn;
        #1;
        exp_mv = mdl_has && (cyc >= mdl_ready);
        exp_sb = mdl_has && (!exp_mv || mb);
        chk("m_valid", {31'd0, m_valid}, {31'd0, exp_mv});
        chk("s_busy", {31'd0, s_busy}, {31'd0, exp_sb});
        if (exp_mv) begin
            chk("m_result", m_result, mdl_res);
            chk("m_rd", {27'd0, m_rd}, {27'd0, mdl_rd});
        end
        if (!rn || fl) begin
            mdl_has = 1'b0;
        end else begin
            if (exp_mv && !mb) mdl_has = 1'b0;
            if (v && !exp_sb) begin
                mdl_has   = 1'b1;
                mdl_ready = cyc + 1 + ref_lat(op, int'(sh));
                mdl_res   = ref_shift(op, rs1, int'(sh));
                mdl_rd    = rd;
            end
        end
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Runs idle cycles until m_valid; returns how many calls that took.
    task automatic wait_valid(output int m);
        m = 0;
        for (int i = 0; i < 100; i++) begin
            idle();
            m++;
            if (m_valid) return;
        end
        chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int m;
        int lat_sll, lat_sra;
`ifdef FRV_SERIAL_SHIFT_FAST_EN
        lat_sll = 2; lat_sra = 11;
`else
        lat_sll = 5; lat_sra = 32;
`endif
        g_resetn = 1'b0; s_valid = 1'b0; s_op = '0; s_rs1 = '0; s_shamt = '0;
        s_rd = '0; flush = 1'b0; m_busy = 1'b0;
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_s_busy", {31'd0, s_busy}, 32'd0);
        chk("reset_m_result", m_result, 32'd0);
        chk("reset_m_rd", {27'd0, m_rd}, 32'd0);

        // SLL 1 by 4
        cycle(1'b1, 2'b00, 32'h0000_0001, 5'd4, 5'd3, 1'b0, 1'b0, 1'b1);
        wait_valid(m);
        chk("sll_latency", m, lat_sll);
        chk("sll_result", m_result, 32'h0000_0010);
        chk("sll_rd", {27'd0, m_rd}, 32'd3);

        // SRA / SRL of MSB by 31
        cycle(1'b1, 2'b10, 32'h8000_0000, 5'd31, 5'd5, 1'b0, 1'b0, 1'b1);
        wait_valid(m);
        chk("sra_latency", m, lat_sra);
        chk("sra_result", m_result, 32'hFFFF_FFFF);
        cycle(1'b1, 2'b01, 32'h8000_0000, 5'd31, 5'd6, 1'b0, 1'b0, 1'b1);
        wait_valid(m);
        chk("srl_result", m_result, 32'h0000_0001);

        // shamt=0 and reserved op with busy hold then back-to-back release
        cycle(1'b1, 2'b00, 32'hDEAD_BEEF, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1);
        wait_valid(m);
        chk("zero_shamt_latency", m, 1);
        chk("zero_shamt_result", m_result, 32'hDEAD_BEEF);
        cycle(1'b1, 2'b11, 32'hDEAD_BEEF, 5'd9, 5'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'b00, 32'h0000_0001, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1);
            chk("hold_result", m_result, 32'hDEAD_BEEF);
            chk("hold_s_busy", {31'd0, s_busy}, 32'd1);
        end
        cycle(1'b1, 2'b00, 32'h0000_0001, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1);
        chk("release_s_busy", {31'd0, s_busy}, 32'd0);
        idle();
        chk("b2b_valid", {31'd0, m_valid}, 32'd1);
        chk("b2b_result", m_result, 32'h0000_0001);
        chk("b2b_rd", {27'd0, m_rd}, 32'd9);

        // flush two cycles into SRL shamt=10
        cycle(1'b1, 2'b01, 32'hF000_0000, 5'd10, 5'd2, 1'b0, 1'b0, 1'b1);
        idle();
        cycle(1'b1, 2'b00, 32'h1234_5678, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 2'b01, 32'h0000_0F00, 5'd8, 5'd11, 1'b0, 1'b0, 1'b1);
        chk("flush_m_valid", {31'd0, m_valid}, 32'd0);
        chk("flush_s_busy", {31'd0, s_busy}, 32'd0);
        wait_valid(m);
        chk("post_flush_result", m_result, 32'h0000_000F);
        chk("post_flush_rd", {27'd0, m_rd}, 32'd11);

        // reset mid-SHIFT
        cycle(1'b1, 2'b00, 32'hFFFF_FFFF, 5'd10, 5'd13, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_mid_m_result", m_result, 32'd0);
        chk("rst_mid_m_rd", {27'd0, m_rd}, 32'd0);
        chk("rst_mid_s_busy", {31'd0, s_busy}, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)),
                  $urandom,
                  5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 149) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
